// File: rtl/config_chain_loader.sv
// Configuration chain writer: accepts words on a valid/ready port and
// shifts them LSB-first into the fabric's configuration flip-flop chain.
module config_chain_loader #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned CHAIN_LEN = 4096,
  parameter int unsigned CNT_W     = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              prog_en,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int unsigned IDX_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_DONE
  } state_e;

  state_e             state_q;
  logic [WORD_W-1:0]  shreg_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               s_ready_q;
  logic               ccff_head_q;
  logic               prog_en_q;
  logic               busy_q;
  logic               done_q;
  logic               aborted_q;

  logic [WORD_W-1:0]  shreg_d;
  logic [IDX_W-1:0]   idx_d;
  logic [CNT_W-1:0]   cnt_d;

  // Next shift-register, word-index and bit-count values while shifting
  assign shreg_d = shreg_q >> 1;
  assign idx_d   = idx_q + IDX_W'(1);
  assign cnt_d   = cnt_q + CNT_W'(1);

  // Loader FSM; ccff_head always presents the bit the chain takes on the next prog_en edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      s_ready_q   <= 1'b0;
      ccff_head_q <= 1'b0;
      prog_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q   <= ST_FETCH;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            cnt_q     <= '0;
          end
        end
        ST_FETCH: begin
          if (abort) begin
            state_q   <= ST_IDLE;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            prog_en_q <= 1'b0;
            aborted_q <= 1'b1;
          end else if (s_valid && s_ready_q) begin
            state_q     <= ST_SHIFT;
            shreg_q     <= s_data;
            idx_q       <= '0;
            ccff_head_q <= s_data[0];
            prog_en_q   <= 1'b1;
            s_ready_q   <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            // Bit count freezes; whatever already went into the chain stays there
            state_q   <= ST_IDLE;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            prog_en_q <= 1'b0;
            aborted_q <= 1'b1;
          end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            if (cnt_d == LAST_CNT) begin
              // Chain full: leftover bits of the current word are dropped
              state_q   <= ST_DONE;
              prog_en_q <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end else if (idx_d == LAST_IDX) begin
              state_q   <= ST_FETCH;
              prog_en_q <= 1'b0;
              s_ready_q <= 1'b1;
            end else begin
              ccff_head_q <= shreg_d[0];
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_ready   = s_ready_q;
  assign ccff_head = ccff_head_q;
  assign prog_en   = prog_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign bit_count = cnt_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader: small 8-bit/20-bit instance for
// the scenario tests plus a default-parameter instance for a full 4096-bit load.
module tb_config_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small instance: WORD_W=8, CHAIN_LEN=20
  logic       a_rst, a_start, a_abort, a_valid;
  logic [7:0] a_data;
  logic       a_ready, a_head, a_pen, a_busy, a_done, a_abrt;
  logic [4:0] a_cnt;

  // Default instance: WORD_W=32, CHAIN_LEN=4096
  logic        b_rst, b_start, b_abort, b_valid;
  logic [31:0] b_data;
  logic        b_ready, b_head, b_pen, b_busy, b_done, b_abrt;
  logic [12:0] b_cnt;

  config_chain_loader #(.WORD_W(8), .CHAIN_LEN(20), .CNT_W(5)) u_a (
    .clk(clk), .reset(a_rst), .start(a_start), .abort(a_abort),
    .s_data(a_data), .s_valid(a_valid), .s_ready(a_ready),
    .ccff_head(a_head), .prog_en(a_pen), .busy(a_busy), .done(a_done),
    .aborted(a_abrt), .bit_count(a_cnt)
  );

  config_chain_loader u_b (
    .clk(clk), .reset(b_rst), .start(b_start), .abort(b_abort),
    .s_data(b_data), .s_valid(b_valid), .s_ready(b_ready),
    .ccff_head(b_head), .prog_en(b_pen), .busy(b_busy), .done(b_done),
    .aborted(b_abrt), .bit_count(b_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic a_chain[$];
  logic b_chain[$];
  int   a_viol = 0;
  int   b_viol = 0;

  logic [7:0]  a_words[3];
  logic [31:0] b_words[128];

  // Chain models: record one bit per prog_en cycle, and watch for s_ready outside FETCH
  always @(negedge clk) begin
    if (a_pen) a_chain.push_back(a_head);
    if (b_pen) b_chain.push_back(b_head);
    if (a_ready && (a_pen || !a_busy || a_done)) a_viol++;
    if (b_ready && (b_pen || !b_busy || b_done)) b_viol++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic start_a(input logic with_abort, output int base);
    a_start = 1'b1;
    a_abort = with_abort;
    @(posedge clk); #1;
    a_start = 1'b0;
    a_abort = 1'b0;
    base = a_chain.size();
  endtask

  // Feeds a_words; optional gap (FETCH cycles with valid low), busy start pulse, abort or reset at a bit count
  task automatic feed_a(input int gap, input int bstart_cyc, input int abort_at,
                        input int reset_at, output int cycles);
    int   widx;
    int   wait_c;
    int   cyc;
    logic hs;
    logic stop;
    widx = 0; wait_c = 0; cyc = 0; stop = 1'b0;
    while (!stop && cyc < 200) begin
      a_start = (cyc == bstart_cyc);
      a_abort = (abort_at >= 0 && int'(a_cnt) == abort_at && a_busy);
      a_rst   = (reset_at >= 0 && int'(a_cnt) == reset_at && a_busy);
      if (wait_c > 0) begin
        a_valid = 1'b0;
        if (a_ready) wait_c--;
      end else if (widx < 3) begin
        a_valid = 1'b1;
        a_data  = a_words[widx];
      end else begin
        a_valid = 1'b0;
      end
      hs = a_valid && a_ready && !a_abort && !a_rst;
      @(posedge clk); #1;
      cyc++;
      if (hs) begin
        widx++;
        wait_c = gap;
      end
      if (a_done || a_abrt || a_rst) stop = 1'b1;
    end
    a_start = 1'b0; a_abort = 1'b0; a_rst = 1'b0; a_valid = 1'b0;
    cycles = cyc;
    chk("feed_a_end", 32'(stop), 32'd1);
  endtask

  function automatic logic [19:0] grab_a(input int base);
    logic [19:0] g;
    g = '0;
    for (int i = 0; i < 20; i++)
      if (base + i < a_chain.size()) g[i] = a_chain[base + i];
    return g;
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int base;
    int cyc;
    int sz;
    int widx;
    int mism;
    logic hs;

    a_rst = 1'b1; a_start = 1'b0; a_abort = 1'b0; a_valid = 1'b0; a_data = '0;
    b_rst = 1'b1; b_start = 1'b0; b_abort = 1'b0; b_valid = 1'b0; b_data = '0;
    a_words[0] = 8'hA5; a_words[1] = 8'h3C; a_words[2] = 8'hFF;
    idle_cycles(3);
    a_rst = 1'b0; b_rst = 1'b0;
    #1;

    // Reset state
    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_head",  32'(a_head),  32'd0);
    chk("rst_pen",   32'(a_pen),   32'd0);
    chk("rst_busy",  32'(a_busy),  32'd0);
    chk("rst_done",  32'(a_done),  32'd0);
    chk("rst_abrt",  32'(a_abrt),  32'd0);
    chk("rst_cnt",   32'(a_cnt),   32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd0);
    chk("rst_b_cnt",   32'(b_cnt),   32'd0);

    // Test 1: back-to-back words, 0xA5 0x3C 0xFF -> 20 bits
    start_a(1'b0, base);
    chk("t1_ready_fetch", 32'(a_ready), 32'd1);
    chk("t1_busy", 32'(a_busy), 32'd1);
    feed_a(0, -1, -1, -1, cyc);
    chk("t1_cycles", 32'(cyc + 1), 32'd24);
    chk("t1_stream", 32'(grab_a(base)), 32'h000F3CA5);
    chk("t1_nbits", 32'(a_chain.size() - base), 32'd20);
    chk("t1_done", 32'(a_done), 32'd1);
    chk("t1_cnt",  32'(a_cnt),  32'd20);
    chk("t1_busy_end", 32'(a_busy), 32'd0);
    // Words offered in DONE must not be taken and nothing else shifts
    a_valid = 1'b1; a_data = 8'h55;
    idle_cycles(3);
    chk("t1_done_ready", 32'(a_ready), 32'd0);
    a_valid = 1'b0;
    chk("t1_done_nbits", 32'(a_chain.size() - base), 32'd20);
    chk("t1_done_hold", 32'(a_done), 32'd1);

    // Test 2: 5 idle FETCH cycles between words, same chain content
    start_a(1'b0, base);
    chk("t2_done_clr", 32'(a_done), 32'd0);
    feed_a(5, -1, -1, -1, cyc);
    chk("t2_cycles", 32'(cyc + 1), 32'd34);
    chk("t2_stream", 32'(grab_a(base)), 32'h000F3CA5);
    chk("t2_nbits", 32'(a_chain.size() - base), 32'd20);
    chk("t2_cnt", 32'(a_cnt), 32'd20);

    // Test 3: abort after 11 bits, then a fresh load
    start_a(1'b0, base);
    feed_a(0, -1, 11, -1, cyc);
    chk("t3_busy", 32'(a_busy), 32'd0);
    chk("t3_abrt", 32'(a_abrt), 32'd1);
    chk("t3_cnt",  32'(a_cnt),  32'd11);
    chk("t3_done", 32'(a_done), 32'd0);
    chk("t3_pen",  32'(a_pen),  32'd0);
    idle_cycles(2);
    chk("t3_abrt_sticky", 32'(a_abrt), 32'd1);
    start_a(1'b0, base);
    chk("t3_abrt_clr", 32'(a_abrt), 32'd0);
    chk("t3_cnt_clr",  32'(a_cnt),  32'd0);
    feed_a(0, -1, -1, -1, cyc);
    chk("t3_stream", 32'(grab_a(base)), 32'h000F3CA5);
    chk("t3_cnt_end", 32'(a_cnt), 32'd20);
    chk("t3_done_end", 32'(a_done), 32'd1);

    // Test 4: start pulse while shifting has no effect
    start_a(1'b0, base);
    feed_a(0, 5, -1, -1, cyc);
    chk("t4_cycles", 32'(cyc + 1), 32'd24);
    chk("t4_stream", 32'(grab_a(base)), 32'h000F3CA5);
    chk("t4_nbits", 32'(a_chain.size() - base), 32'd20);

    // Test 5: reset at bit 7 mid-load
    start_a(1'b0, base);
    feed_a(0, -1, -1, 7, cyc);
    chk("t5_ready", 32'(a_ready), 32'd0);
    chk("t5_head",  32'(a_head),  32'd0);
    chk("t5_pen",   32'(a_pen),   32'd0);
    chk("t5_busy",  32'(a_busy),  32'd0);
    chk("t5_done",  32'(a_done),  32'd0);
    chk("t5_cnt",   32'(a_cnt),   32'd0);
    sz = a_chain.size();
    a_valid = 1'b1; a_data = 8'hA5;
    idle_cycles(4);
    chk("t5_no_accept", 32'(a_ready), 32'd0);
    chk("t5_no_shift", 32'(a_chain.size() - sz), 32'd0);
    a_valid = 1'b0;

    // Test 6: abort early, then start+abort together in IDLE starts a clean load
    start_a(1'b0, base);
    feed_a(0, -1, 5, -1, cyc);
    chk("t6_abrt", 32'(a_abrt), 32'd1);
    chk("t6_cnt", 32'(a_cnt), 32'd5);
    start_a(1'b1, base);
    chk("t6_busy", 32'(a_busy), 32'd1);
    chk("t6_abrt_clr", 32'(a_abrt), 32'd0);
    chk("t6_ready", 32'(a_ready), 32'd1);
    feed_a(0, -1, -1, -1, cyc);
    chk("t6_stream", 32'(grab_a(base)), 32'h000F3CA5);
    chk("t6_done", 32'(a_done), 32'd1);
    chk("a_ready_outside_fetch", 32'(a_viol), 32'd0);

    // Test 7: default parameters, 128 random words with random valid gaps
    for (int i = 0; i < 128; i++) b_words[i] = $urandom;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    base = b_chain.size();
    widx = 0; cyc = 0;
    while (!b_done && cyc < 20000) begin
      if (widx < 128 && $urandom_range(0, 3) != 0) begin
        b_valid = 1'b1;
        b_data  = b_words[widx];
      end else begin
        b_valid = 1'b0;
      end
      hs = b_valid && b_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) widx++;
    end
    b_valid = 1'b0;
    mism = 0;
    for (int i = 0; i < 4096; i++)
      if (base + i >= b_chain.size() || b_chain[base + i] !== b_words[i / 32][i % 32]) mism++;
    chk("t7_done", 32'(b_done), 32'd1);
    chk("t7_cnt", 32'(b_cnt), 32'd4096);
    chk("t7_nbits", 32'(b_chain.size() - base), 32'd4096);
    chk("t7_chain_mism", 32'(mism), 32'd0);
    chk("t7_words_taken", 32'(widx), 32'd128);
    chk("t7_ready_outside_fetch", 32'(b_viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/config_chain_loader.md
Name: config_chain_loader

Overview:
- Streams configuration words into the fabric's configuration flip-flop chain: accepts words on a valid/ready port and shifts CHAIN_LEN bits serially into ccff_head.
- Gates each shift with a one-cycle prog_en, and reports completion or abort.
- Sits between the bitstream source (SPI/UART front end) and the fabric top's ccff_head input. It is the writer end of the chain that the fabric's configuration cells and constant tie cells are programmed through.

Parameters:
- WORD_W, 32, width of each input configuration word
- CHAIN_LEN, 4096, total configuration bits in the chain (>=1)
- CNT_W, 13, bit-counter width; must satisfy 2**CNT_W > CHAIN_LEN

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  pulse; begins a load when in IDLE, ignored otherwise
- abort  input  1  pulse; cancels an in-progress load
- s_data  input  WORD_W  configuration word; bit 0 is shifted first
- s_valid  input  1  s_data valid
- s_ready  output  1  loader can accept a word this cycle
- ccff_head  output  1  serial configuration bit to the chain
- prog_en  output  1  chain shift enable; chain samples ccff_head on a clk edge where prog_en=1
- busy  output  1  high in FETCH/SHIFT
- done  output  1  high in DONE until next start or reset
- aborted  output  1  sticky; set by abort, cleared by start or reset
- bit_count  output  CNT_W  bits shifted so far in the current load

Behaviour:
- All outputs are registered. Reset values: s_ready=0, ccff_head=0, prog_en=0, busy=0, done=0, aborted=0, bit_count=0, FSM state=IDLE. Reset wins over every other input in the same cycle, including mid-load.
- IDLE: start=1 -> FETCH, bit_count<=0, done<=0, aborted<=0.
- FETCH: s_ready=1. Handshake completes when s_valid && s_ready on the same edge: the word is latched into the shift register, bit index<=0, next state SHIFT. If s_valid=0, the FSM stays in FETCH with prog_en=0; the chain holds.
- SHIFT: each cycle drives ccff_head=shreg[idx] with prog_en=1, idx++, bit_count++.
  - If bit_count reaches CHAIN_LEN -> DONE. Remaining bits of the current word are discarded.
  - Else if idx reaches WORD_W -> FETCH.
  - Exactly one bit per prog_en cycle. ccff_head and prog_en change on the same edge.
- Minimum word-to-word cost is WORD_W shift cycles + 1 FETCH cycle. s_ready is low throughout SHIFT.
- Total load cycles with s_valid held at 1: CHAIN_LEN + ceil(CHAIN_LEN/WORD_W) after start, plus 1 cycle IDLE->FETCH.
- DONE: done=1, busy=0, prog_en=0, s_ready=0. Words presented in DONE are not accepted. start -> FETCH (new load, done cleared).
- abort in FETCH or SHIFT: on the next edge -> IDLE, prog_en=0, aborted=1. bit_count freezes at its value; the partial load is left in the chain. abort in IDLE/DONE is ignored.
- start and abort asserted together in IDLE: start is taken and abort ignored. In FETCH/SHIFT, abort wins and start is ignored.
- start asserted while busy is ignored.
- ccff_head holds its last value when prog_en=0. Downstream logic must ignore it when prog_en=0.

Test Plan:
- WORD_W=8, CHAIN_LEN=20; feed 0xA5, 0x3C, 0xFF with s_valid held high -> serial stream 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1. Exactly 20 prog_en pulses, last 4 bits of 0xFF dropped, done=1, bit_count=20, and 0xFF's remaining bits not shifted.
- Same config with s_valid low for 5 cycles between words -> prog_en low during gaps, no extra bits shifted, chain model content identical to the previous test.
- abort after 11 shifted bits -> IDLE next cycle, aborted=1, bit_count=11, done=0. Then start -> aborted=0, bit_count=0, fresh load completes with 20 bits.
- reset asserted in SHIFT at bit 7 -> next cycle all outputs at reset values; s_valid on following cycles not accepted until start.
- start while busy and start+abort in IDLE -> busy-start has no effect on bit sequence; IDLE case begins load with aborted=0.
- Default params, random 128 words with random valid gaps -> scoreboarded 4096-bit chain matches the first 4096 input bits LSB-first, done=1, s_ready never high outside FETCH.
